// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Four-requester round-robin arbiter and sequencer for the
//               single shared memory port, with per-transaction timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req,
  input  logic [3:0]              we,
  input  logic [4*ADDR_WIDTH-1:0] addr,
  input  logic [4*DATA_WIDTH-1:0] wdata,
  output logic [3:0]              done,
  output logic [3:0]              err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              sel,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit c_to_en = (TIMEOUT != 0);
  localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_last, w_last_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [3:0]            r_done, w_done_nxt;
  logic [3:0]            r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]            r_sel, w_sel_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;

  logic [3:0]            w_elig;
  logic                  w_found;
  logic [1:0]            w_win;
  logic [1:0]            w_idx;

  // A requester pulsing done/err this cycle sits out one arbitration round.
  always_comb begin
    w_elig  = req & ~(r_done | r_err);
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_done_nxt      = 4'b0000;
    w_err_nxt       = 4'b0000;
    w_rdata_nxt     = r_rdata;
    w_sel_nxt       = r_sel;
    w_busy_nxt      = r_busy;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_BUSY;
          w_sel_nxt       = w_win;
          w_mem_we_nxt    = we[w_win];
          w_mem_addr_nxt  = addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
          w_mem_wdata_nxt = wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
          w_mem_req_nxt   = 1'b1;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_rdata_nxt   = mem_rdata;
          w_done_nxt    = 4'b0001 << r_sel;
          w_last_nxt    = r_sel;
          w_mem_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (c_to_en && (r_cnt == c_term)) begin
          w_err_nxt     = 4'b0001 << r_sel;
          w_last_nxt    = r_sel;
          w_mem_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 2'd3;
      r_cnt       <= '0;
      r_done      <= 4'b0000;
      r_err       <= 4'b0000;
      r_rdata     <= '0;
      r_sel       <= 2'd0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_sel       <= w_sel_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scenarios plus randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    we = '0;
  logic [4*AW-1:0] addr = '0;
  logic [4*DW-1:0] wdata = '0;
  logic [3:0]    done;
  logic [3:0]    err;
  logic [DW-1:0] rdata;
  logic [1:0]    sel;
  logic          busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .err(err), .rdata(rdata), .sel(sel), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: one pending transaction with an age, a round-robin pointer.
  logic          m_busy = 0;
  logic [3:0]    m_done = 0, m_err = 0, m_elig;
  logic [DW-1:0] m_rdata = 0;
  logic [1:0]    m_sel = 0, m_last = 3, m_idx;
  logic          m_we = 0, m_found;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0;
  int            m_age = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_rdata = 0; m_sel = 0; m_last = 3;
      m_we = 0; m_addr = 0; m_wdata = 0; m_age = 0;
    end else if (!m_busy) begin
      m_elig = req & ~(m_done | m_err);
      m_done = 0;
      m_err  = 0;
      m_found = 0;
      for (int k = 1; k <= 4; k++) begin
        m_idx = 2'((m_last + k) % 4);
        if (!m_found && m_elig[m_idx]) begin
          m_found = 1;
          m_sel   = m_idx;
          m_we    = we[m_idx];
          m_addr  = addr[m_idx*AW +: AW];
          m_wdata = wdata[m_idx*DW +: DW];
          m_busy  = 1;
          m_age   = 0;
        end
      end
    end else if (mem_ack) begin
      m_rdata = mem_rdata;
      m_done  = 4'b0001 << m_sel;
      m_last  = m_sel;
      m_busy  = 0;
    end else if (m_age == TO - 1) begin
      m_err  = 4'b0001 << m_sel;
      m_last = m_sel;
      m_busy = 0;
    end else begin
      m_age = m_age + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req = 0; we = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({done, err, sel, busy, mem_req, mem_we} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got done=%b err=%b sel=%0d busy=%b mem_req=%b mem_we=%b, want all zero",
               done, err, sel, busy, mem_req, mem_we);
    end
    checks++;
    if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h mem_addr=%h mem_wdata=%h, want 0", rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_read();
    do_reset();
    req = 4'b0001; we = 0; addr[0 +: AW] = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, sel, mem_addr} !== {1'b1, 1'b0, 2'd0, 32'h100}) begin
      errors++;
      $display("FAIL read_grant: got mem_req=%b mem_we=%b sel=%0d mem_addr=%h, want 1 0 0 00000100",
               mem_req, mem_we, sel, mem_addr);
    end
    req = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({done, rdata, busy} !== {4'b0001, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL read_done: got done=%b rdata=%h busy=%b, want 0001 deadbeef 0", done, rdata, busy);
    end
    @(negedge clk);
    checks++;
    if ({done, rdata} !== {4'b0000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL read_pulse: got done=%b rdata=%h, want 0000 deadbeef", done, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel;
    do_reset();
    req = 4'b1111; mem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      exp_sel = 2'(i % 4);
      @(negedge clk);
      checks++;
      if ({mem_req, sel} !== {1'b1, exp_sel}) begin
        errors++;
        $display("FAIL rr_grant%0d: got mem_req=%b sel=%0d, want 1 %0d", i, mem_req, sel, exp_sel);
      end
      @(negedge clk);
      checks++;
      if ({done, err, busy} !== {4'b0001 << exp_sel, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL rr_done%0d: got done=%b err=%b busy=%b, want %b 0000 0",
                 i, done, err, busy, 4'b0001 << exp_sel);
      end
    end
    req = 0; mem_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_no_regrant();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({done, mem_req} !== {4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL noregrant_done: got done=%b mem_req=%b, want 0100 0", done, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({done, mem_req} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL noregrant_gap: got done=%b mem_req=%b, want 0000 0", done, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, sel} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL noregrant_again: got mem_req=%b sel=%0d, want 1 2", mem_req, sel);
    end
    req = 0; mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_write_hold();
    do_reset();
    req = 4'b0010; we = 4'b0010; addr[AW +: AW] = 32'h40; wdata[DW +: DW] = 32'h55;
    @(negedge clk);
    req = 0; we = 0; addr[AW +: AW] = 32'h80; wdata[DW +: DW] = 32'h99;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, sel} !== {1'b1, 32'h40, 32'h55, 2'd1}) begin
      errors++;
      $display("FAIL write_hold: got we=%b addr=%h wdata=%h sel=%0d, want 1 00000040 00000055 1",
               mem_we, mem_addr, mem_wdata, sel);
    end
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({done, mem_addr, rdata} !== {4'b0010, 32'h40, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL write_done: got done=%b addr=%h rdata=%h, want 0010 00000040 0badf00d",
               done, mem_addr, rdata);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    req = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if ({err, done, busy, sel} !== {4'b0000, 4'b0000, 1'b1, 2'd3}) begin
        errors++;
        $display("FAIL timeout_wait%0d: got err=%b done=%b busy=%b sel=%0d, want 0000 0000 1 3",
                 i, err, done, busy, sel);
      end
    end
    @(negedge clk);
    checks++;
    if ({err, done, rdata, busy, mem_req} !== {4'b1000, 4'b0000, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_err: got err=%b done=%b rdata=%h busy=%b mem_req=%b, want 1000 0000 0 0 0",
               err, done, rdata, busy, mem_req);
    end
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({err, done, rdata, busy, mem_req} !== {4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_stray_ack: got err=%b done=%b rdata=%h busy=%b mem_req=%b, want 0 0 0 0 0",
               err, done, rdata, busy, mem_req);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    req = 4'b0110;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, sel} !== {1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_busy: got mem_req=%b busy=%b sel=%0d, want 0 0 0", mem_req, busy, sel);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, sel} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL reset_first_win: got mem_req=%b sel=%0d, want 1 1", mem_req, sel);
    end
    req = 0; mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_random();
    logic [108:0] got, exp;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      got = {done, err, rdata, sel, busy, mem_req, mem_we, mem_addr, mem_wdata};
      exp = {m_done, m_err, m_rdata, m_sel, m_busy, m_busy, m_we, m_addr, m_wdata};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h, want %h (done,err,rdata,sel,busy,mem_req,mem_we,mem_addr,mem_wdata)",
                 cyc, got, exp);
      end
      rst       = ($urandom_range(99) == 0);
      req       = 4'($urandom);
      we        = 4'($urandom);
      mem_ack   = ($urandom_range(99) < 35);
      mem_rdata = $urandom;
      for (int i = 0; i < 4; i++) begin
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
      end
    end
    rst = 0; req = 0; mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_no_regrant();
    test_write_hold();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
